// File: rtl/core_pkg.sv
// Shared front-end definitions: FSM state, redirect cause and fetch defaults.
package core_pkg;

  localparam int DEF_IALIGN = 4;
  localparam int DEF_STEP   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } state_t;

  // Reason for the redirect that produced the current pc_out; NONE otherwise.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2,
    BR   = 2'd3
  } cause_t;

endpackage

// File: rtl/pc_target.sv
// Branch target computation: base + offset, bit0 clear for absolute (jalr)
// targets, and an alignment flag against the instruction alignment.
module pc_target
  import core_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IALIGN = DEF_IALIGN
) (
  input  logic             abs,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] target,
  output logic             misalign
);

  logic [WIDTH-1:0] sum;

  // Adder, jalr-style clear and alignment check; IALIGN=2 only looks at bit0,
  // which is always zero for absolute targets.
  always_comb begin
    sum      = base + offset;
    target   = abs ? {sum[WIDTH-1:1], 1'b0} : sum;
    misalign = (IALIGN == 2) ? target[0] : target[1];
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator for the fetch front end.
//
// Handshake: pc_out is a fetch request while pc_valid=1 and is consumed on a
// cycle with pc_valid=1 && pc_ready=1. Without a redirect, pc_out and pc_valid
// stay stable while pc_valid=1 && pc_ready=0. A redirect (trap, mret, aligned
// branch) may replace pc_out regardless of pc_ready; fetch_kill is then high
// for exactly the cycle the new pc_out appears, telling fetch to drop the old
// request.
module pc_gen
  import core_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               IALIGN    = DEF_IALIGN,
  parameter int               STEP      = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_abs,
  input  logic [WIDTH-1:0] br_base,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             ret_valid,
  input  logic [WIDTH-1:0] ret_epc,
  input  logic             wfi_req,
  input  logic             wake,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic             fetch_kill,
  output logic             misalign,
  output logic [WIDTH-1:0] misalign_addr,
  output state_t           state,
  output cause_t           cause
);

  localparam logic [WIDTH-1:0] RET_MASK = ~WIDTH'(IALIGN - 1);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  logic [WIDTH-1:0] br_target;
  logic             br_misalign;
  logic [WIDTH-1:0] trap_target;
  logic [WIDTH-1:0] ret_target;

  pc_target #(
    .WIDTH  (WIDTH),
    .IALIGN (IALIGN)
  ) u_target (
    .abs      (br_abs),
    .base     (br_base),
    .offset   (br_offset),
    .target   (br_target),
    .misalign (br_misalign)
  );

  // Trap vectors are word aligned; mepc is cleared to instruction alignment.
  always_comb begin
    trap_target = {trap_vec[WIDTH-1:2], 2'b00};
    ret_target  = ret_epc & RET_MASK;
  end

  // Control FSM with registered outputs; redirects take priority in every
  // state except BOOT, where the pipeline is empty and requests are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc_out        <= RESET_VEC;
      pc_valid      <= 1'b0;
      fetch_kill    <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      cause         <= NONE;
    end else begin
      fetch_kill <= 1'b0;
      misalign   <= 1'b0;
      cause      <= NONE;
      if (state == BOOT) begin
        state    <= RUN;
        pc_valid <= 1'b1;
      end else if (trap_valid) begin
        pc_out     <= trap_target;
        fetch_kill <= 1'b1;
        cause      <= TRAP;
        state      <= RUN;
        pc_valid   <= 1'b1;
      end else if (ret_valid) begin
        pc_out     <= ret_target;
        fetch_kill <= 1'b1;
        cause      <= RET;
        state      <= RUN;
        pc_valid   <= 1'b1;
      end else if (br_valid && !br_misalign) begin
        pc_out     <= br_target;
        fetch_kill <= 1'b1;
        cause      <= BR;
      end else if (br_valid) begin
        misalign      <= 1'b1;
        misalign_addr <= br_target;
      end else if (state == RUN && pc_ready && !stall) begin
        pc_out <= pc_out + STEP_W;
        if (wfi_req) begin
          state    <= SLEEP;
          pc_valid <= 1'b0;
        end
      end else if (state == SLEEP && wake) begin
        state    <= RUN;
        pc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: vector table plus hand sequences, checked through a
// scoreboard queue of expected output words.
module tb_pc_gen;
  import core_pkg::*;

  localparam int W = 32;
  localparam int EW = W + 1 + 1 + 1 + W;

  typedef struct packed {
    logic         rst;
    logic         stall;
    logic         pc_ready;
    logic         br_valid;
    logic         br_abs;
    logic [W-1:0] br_base;
    logic [W-1:0] br_offset;
    logic         trap_valid;
    logic [W-1:0] trap_vec;
    logic         ret_valid;
    logic [W-1:0] ret_epc;
    logic         wfi_req;
    logic         wake;
  } in_t;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         valid;
    logic         kill;
    logic         mis;
    logic [W-1:0] maddr;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst, stall, br_valid, br_abs, trap_valid, ret_valid;
  logic         wfi_req, wake, pc_ready;
  logic [W-1:0] br_base, br_offset, trap_vec, ret_epc;
  logic [W-1:0] pc_out, misalign_addr;
  logic         pc_valid, fetch_kill, misalign;
  state_t       state;
  cause_t       cause;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .br_valid      (br_valid),
    .br_abs        (br_abs),
    .br_base       (br_base),
    .br_offset     (br_offset),
    .trap_valid    (trap_valid),
    .trap_vec      (trap_vec),
    .ret_valid     (ret_valid),
    .ret_epc       (ret_epc),
    .wfi_req       (wfi_req),
    .wake          (wake),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .fetch_kill    (fetch_kill),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .state         (state),
    .cause         (cause)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic in_t idle(input logic ready);
    in_t t;
    t = '0;
    t.pc_ready = ready;
    return t;
  endfunction

  function automatic in_t br(input logic abs, input logic [W-1:0] base,
                             input logic [W-1:0] off, input logic ready);
    in_t t;
    t = idle(ready);
    t.br_valid  = 1'b1;
    t.br_abs    = abs;
    t.br_base   = base;
    t.br_offset = off;
    return t;
  endfunction

  function automatic out_t ex(input logic [W-1:0] pc, input logic v, input logic k,
                              input logic m, input logic [W-1:0] ma);
    out_t o;
    o.pc = pc; o.valid = v; o.kill = k; o.mis = m; o.maddr = ma;
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input in_t t);
    rst = t.rst; stall = t.stall; pc_ready = t.pc_ready;
    br_valid = t.br_valid; br_abs = t.br_abs; br_base = t.br_base; br_offset = t.br_offset;
    trap_valid = t.trap_valid; trap_vec = t.trap_vec;
    ret_valid = t.ret_valid; ret_epc = t.ret_epc;
    wfi_req = t.wfi_req; wake = t.wake;
  endtask

  task automatic check(input string name);
    out_t e, a;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = out_t'(exp_q.pop_front());
    a = ex(pc_out, pc_valid, fetch_kill, misalign, misalign_addr);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc=%h valid=%b kill=%b mis=%b maddr=%h, expected pc=%h valid=%b kill=%b mis=%b maddr=%h",
               name, a.pc, a.valid, a.kill, a.mis, a.maddr, e.pc, e.valid, e.kill, e.mis, e.maddr);
    end
  endtask

  // Drive one cycle's inputs at negedge, then check the registered outputs after posedge.
  task automatic cyc(input string name, input in_t t, input out_t e);
    @(negedge clk);
    drive(t);
    exp_q.push_back(EW'(e));
    @(posedge clk);
    #1;
    check(name);
  endtask

  vec_t tbl[$];

  task automatic add(input string name, input in_t t, input out_t e);
    vec_t v;
    v.name = name; v.i = t; v.e = e;
    tbl.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_t t;
    logic [W-1:0] m;
    drive(idle(1'b0));

    t = idle(1'b1); t.rst = 1'b1;
    add("reset0", t, ex(32'h0, 0, 0, 0, 32'h0));
    add("reset1", t, ex(32'h0, 0, 0, 0, 32'h0));
    add("boot_exit", idle(1'b1), ex(32'h0, 1, 0, 0, 32'h0));
    add("seq_4", idle(1'b1), ex(32'h4, 1, 0, 0, 32'h0));
    add("seq_8", idle(1'b1), ex(32'h8, 1, 0, 0, 32'h0));
    add("br_to_100", br(0, 32'hF8, 32'h8, 1), ex(32'h100, 1, 1, 0, 32'h0));
    for (int k = 0; k < 3; k++)
      add("ready_low_hold", idle(1'b0), ex(32'h100, 1, 0, 0, 32'h0));
    add("ready_adv", idle(1'b1), ex(32'h104, 1, 0, 0, 32'h0));
    add("br_rel_neg", br(0, 32'h100, 32'hFFFF_FFF0, 1), ex(32'hF0, 1, 1, 0, 32'h0));
    add("kill_one_cycle", idle(1'b0), ex(32'hF0, 1, 0, 0, 32'h0));
    add("br_abs_mis", br(1, 32'h200, 32'h3, 1), ex(32'hF0, 1, 0, 1, 32'h202));
    add("mis_pulse_end", idle(1'b0), ex(32'hF0, 1, 0, 0, 32'h202));
    add("br_abs_ok_notready", br(1, 32'h301, 32'h3, 0), ex(32'h304, 1, 1, 0, 32'h202));
    add("br_rel_mis", br(0, 32'h10, 32'h2, 1), ex(32'h304, 1, 0, 1, 32'h12));
    t = br(0, 32'h500, 32'h0, 1);
    t.trap_valid = 1'b1; t.trap_vec = 32'h8000_0005;
    t.ret_valid = 1'b1; t.ret_epc = 32'h1236;
    add("prio_trap", t, ex(32'h8000_0004, 1, 1, 0, 32'h12));
    t.trap_valid = 1'b0;
    add("prio_ret", t, ex(32'h1234, 1, 1, 0, 32'h12));
    t = idle(1'b1); t.stall = 1'b1;
    add("stall_hold", t, ex(32'h1234, 1, 0, 0, 32'h12));
    t = br(0, 32'h400, 32'h0, 0); t.stall = 1'b1;
    add("br_ignores_stall", t, ex(32'h400, 1, 1, 0, 32'h12));

    for (int k = 0; k < tbl.size(); k++)
      cyc(tbl[k].name, tbl[k].i, tbl[k].e);

    // WFI: blocked by stall / !pc_ready, taken on the accepting cycle, then wake.
    m = 32'h12;
    cyc("wfi_setup", br(0, 32'h40, 32'h0, 1), ex(32'h40, 1, 1, 0, m));
    t = idle(1'b1); t.stall = 1'b1; t.wfi_req = 1'b1;
    cyc("wfi_stalled", t, ex(32'h40, 1, 0, 0, m));
    t = idle(1'b0); t.wfi_req = 1'b1;
    cyc("wfi_not_ready", t, ex(32'h40, 1, 0, 0, m));
    t = idle(1'b1); t.wfi_req = 1'b1;
    cyc("wfi_accept", t, ex(32'h44, 0, 0, 0, m));
    for (int k = 0; k < 5; k++)
      cyc("sleep_hold", idle(1'b1), ex(32'h44, 0, 0, 0, m));
    t = idle(1'b1); t.wake = 1'b1;
    cyc("wake_resume", t, ex(32'h44, 1, 0, 0, m));
    cyc("after_wake", idle(1'b1), ex(32'h48, 1, 0, 0, m));

    // Branch inside SLEEP is applied but stays asleep; mret wakes.
    t = idle(1'b1); t.wfi_req = 1'b1;
    cyc("wfi_again", t, ex(32'h4C, 0, 0, 0, m));
    cyc("sleep_br", br(0, 32'h80, 32'h0, 1), ex(32'h80, 0, 1, 0, m));
    cyc("sleep_br_stays", idle(1'b1), ex(32'h80, 0, 0, 0, m));
    t = idle(1'b1); t.ret_valid = 1'b1; t.ret_epc = 32'h8A;
    cyc("sleep_ret", t, ex(32'h88, 1, 1, 0, m));

    // Address wrap.
    cyc("to_top", br(0, 32'hFFFF_FFF0, 32'hC, 1), ex(32'hFFFF_FFFC, 1, 1, 0, m));
    cyc("wrap", idle(1'b1), ex(32'h0, 1, 0, 0, m));

    // Reset while asleep with a pending branch, then a request during BOOT.
    t = idle(1'b1); t.wfi_req = 1'b1;
    cyc("wfi_pre_reset", t, ex(32'h4, 0, 0, 0, m));
    t = br(0, 32'h100, 32'h0, 1); t.rst = 1'b1;
    cyc("reset_in_sleep", t, ex(32'h0, 0, 0, 0, 32'h0));
    t = br(0, 32'h500, 32'h0, 1); t.trap_valid = 1'b1; t.trap_vec = 32'h900;
    cyc("boot_drops_req", t, ex(32'h0, 1, 0, 0, 32'h0));
    cyc("post_boot_adv", idle(1'b1), ex(32'h4, 1, 0, 0, 32'h0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
